mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates a single multi-cycle unified memory between the pipeline's instruction-fetch port (read-only) and the MEM-stage data port (read/write). Latches each request, drives the memory until completion, returns one-cycle acknowledge pulses with registered read data, and produces the stall signals the hazard logic uses to freeze the pipeline. Sits between the IF/MEM stages of `cpu` and the memory model. It replaces the two single-cycle `memory1c` instances.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `TIMEOUT`, 15, maximum BUSY cycles awaiting `mem_valid` before forced completion (≥2)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `i_req`  in  1  fetch request, held until `i_ack`
- `i_addr`  in  ADDR_W  fetch address
- `i_cancel`  in  1  branch flush: discard in-flight fetch result
- `i_ack`  out  1  one-cycle completion pulse, fetch
- `i_rdata`  out  DATA_W  fetch data, valid with `i_ack`
- `i_stall`  out  1  `i_req & ~i_ack`
- `d_req`  in  1  data request, held until `d_ack`
- `d_wr`  in  1  1 = write, 0 = read
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  write data
- `d_ack`  out  1  one-cycle completion pulse, data
- `d_rdata`  out  DATA_W  read data, valid with `d_ack` (0 for writes)
- `d_stall`  out  1  `d_req & ~d_ack`
- `mem_enable`  out  1  high for every BUSY cycle
- `mem_wr`  out  1  write strobe, BUSY_D write only
- `mem_addr`  out  ADDR_W  latched address
- `mem_wdata`  out  DATA_W  latched write data
- `mem_rdata`  in  DATA_W  memory read data
- `mem_valid`  in  1  read data valid this cycle
- `err`  out  1  sticky: a read timed out

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE: `d_req` → BUSY_D, else `i_req` → BUSY_I. D has priority when both are asserted. On entry, latch addr, wr, and wdata; clear the timeout counter and the cancel flag.
- BUSY_D write: exactly one cycle with `mem_wr=1`, then RESP_D.
- BUSY_I and BUSY_D read: hold `mem_enable`, `mem_addr` stable. On `mem_valid`, register `mem_rdata`, then go to RESP.
- Timeout: if the counter reaches TIMEOUT with no `mem_valid`, set `err`, register rdata=0, and go to RESP. The counter saturates and never wraps.
- RESP_x: assert `x_ack` and the registered `x_rdata` for one cycle. Next state is BUSY of the *other* requester if its req is high, else IDLE. The just-acked requester's req is still high this cycle and must be ignored. This also gives alternation under contention.
- Cancel: `i_cancel` in the BUSY_I cycle sets the cancel flag. `i_cancel` sampled in IDLE together with a granted `i_req` also sets it. At completion with the flag set, go from BUSY_I directly to IDLE, with no `i_ack` and `i_rdata` unchanged. The memory transaction is never aborted mid-flight.
- `i_cancel` in RESP_I has no effect; the ack is still issued.
- `i_stall` and `d_stall` are combinational. All other outputs are registered or decoded from state.

## Timing
- Reset values: state IDLE, all acks 0, `mem_enable`/`mem_wr` 0, `mem_addr`/`mem_wdata`/`i_rdata`/`d_rdata` 0, `err` 0, counter 0.
- Reset asserted mid-transaction aborts immediately; no ack is issued.
- Read latency: req sampled at edge 0, BUSY from cycle 1. If the memory asserts `mem_valid` in its L-th BUSY cycle, the ack is in cycle L+1.
- Write latency: BUSY in cycle 1, ack in cycle 2.
- Requesters must keep addr and data stable only until the grant edge; the values are latched.
- Back-to-back service: ack of one port to BUSY of the other adds no idle cycle.

## Structure
- `mem_arb_pkg`: state enum and a `ST_W` constant for the state width.
- No sub-module. The counter and FSM are inline.

## Test plan
- I read, memory L=3, addr 0x0010 → data 0xA5A5: `mem_enable` high in cycles 1–3, `i_ack`=1 with 0xA5A5 in cycle 4, `i_stall` high in cycles 0–3.
- `i_req` and `d_req` (read 0x0200) asserted together → D granted first, `d_ack` at L+1, BUSY_I the next cycle, `i_ack` at 2L+2. No cycle grants D twice.
- D write 0x0300 ← 0x1234 → `mem_wr`=1 only in cycle 1 with that address and data, `d_ack` in cycle 2, `d_rdata`=0.
- `i_cancel` pulse in cycle 2 of an I read → no `i_ack`, FSM returns to IDLE after `mem_valid`, and a new `i_req` at 0x0040 is then served normally.
- `mem_valid` never asserted, TIMEOUT=15 → ack after 15 BUSY cycles with rdata=0, and `err`=1 sticky until `rst`.
- `rst` pulsed in BUSY_D write cycle → all outputs return to their reset values asynchronously, no `d_ack`, and a re-issued request is served normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter between fetch and data ports.
package mem_arb_pkg;
  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE,
    ST_BUSY_I,
    ST_BUSY_D,
    ST_RESP_I,
    ST_RESP_D
  } state_e;
endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one multi-cycle memory between the fetch (read-only) and data ports,
// latching each request and returning one-cycle acks with registered read data.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_cancel,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              err
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cancel_q, cancel_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic grant_i, grant_d, tmo, rd_done;
  logic [DATA_W-1:0] rd_val;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    cancel_d  = cancel_q;
    err_d     = err_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    // Counter holds the number of BUSY cycles already elapsed.
    tmo       = (cnt_q >= CNT_W'(TIMEOUT - 1));
    rd_done   = mem_valid | tmo;
    rd_val    = mem_valid ? mem_rdata : '0;

    if ((state_q == ST_BUSY_I || state_q == ST_BUSY_D) && cnt_q != CNT_W'(TIMEOUT))
      cnt_d = cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (d_req)      grant_d = 1'b1;
        else if (i_req) grant_i = 1'b1;
      end
      ST_BUSY_I: begin
        cancel_d = cancel_q | i_cancel;
        if (rd_done) begin
          if (!mem_valid) err_d = 1'b1;
          if (cancel_d) state_d = ST_IDLE;
          else begin
            i_rdata_d = rd_val;
            state_d   = ST_RESP_I;
          end
        end
      end
      ST_BUSY_D: begin
        if (wr_q) begin
          d_rdata_d = '0;
          state_d   = ST_RESP_D;
        end else if (rd_done) begin
          if (!mem_valid) err_d = 1'b1;
          d_rdata_d = rd_val;
          state_d   = ST_RESP_D;
        end
      end
      // The just-acked port still holds req this cycle, so only the other port is looked at.
      ST_RESP_I: begin
        if (d_req) grant_d = 1'b1;
        else       state_d = ST_IDLE;
      end
      ST_RESP_D: begin
        if (i_req) grant_i = 1'b1;
        else       state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (grant_d) begin
      state_d  = ST_BUSY_D;
      addr_d   = d_addr;
      wr_d     = d_wr;
      wdata_d  = d_wdata;
      cnt_d    = '0;
      cancel_d = 1'b0;
    end else if (grant_i) begin
      state_d  = ST_BUSY_I;
      addr_d   = i_addr;
      wr_d     = 1'b0;
      wdata_d  = '0;
      cnt_d    = '0;
      cancel_d = (state_q == ST_IDLE) & i_cancel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      cancel_q  <= 1'b0;
      err_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      cancel_q  <= cancel_d;
      err_q     <= err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign i_ack      = (state_q == ST_RESP_I);
  assign d_ack      = (state_q == ST_RESP_D);
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign i_stall    = i_req & ~i_ack;
  assign d_stall    = d_req & ~d_ack;
  assign mem_enable = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);
  assign mem_wr     = (state_q == ST_BUSY_D) & wr_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign err        = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: fixed vectors, hand-written corner sequences, and random
// transactions checked against a transaction-level memory model.
module tb_mem_arbiter;
  localparam int TMO = 15;

  logic        clk = 1'b0, rst = 1'b1;
  logic        i_req = 0, i_cancel = 0, d_req = 0, d_wr = 0;
  logic [15:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic        i_ack, i_stall, d_ack, d_stall, mem_enable, mem_wr, mem_valid, err;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_cancel(i_cancel), .i_ack(i_ack),
    .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid), .err(err)
  );

  always #5 clk = ~clk;

  // Memory environment: answers in the lat-th consecutive enable cycle; lat=0 never answers.
  logic [15:0] memarr  [0:65535];
  logic [15:0] ref_mem [0:65535];
  int          lat = 1;
  int          bcnt = 0;

  always_comb begin
    mem_valid = mem_enable && (lat != 0) && (bcnt == lat - 1);
    mem_rdata = mem_valid ? memarr[mem_addr] : 16'hDEAD;
  end

  always @(posedge clk) begin
    bcnt <= mem_enable ? bcnt + 1 : 0;
    if (mem_enable && mem_wr) memarr[mem_addr] <= mem_wdata;
  end

  int          n_chk = 0, n_pass = 0;
  bit          exp_err = 0;
  logic [15:0] last_i = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // One arbitration episode; requests raised in cycle 0, acks timed in cycles after.
  task automatic xact(input bit di, input bit dd, input bit dw,
                      input logic [15:0] ia, input logic [15:0] da, input logic [15:0] wd,
                      input int l, input int eic, input int edc,
                      input logic [15:0] eid, input logic [15:0] edd, input string nm);
    int gi, gd, ni, nd, nb, nst, leff, ebusy, last;
    logic [15:0] gid, gdd;
    leff  = (l == 0) ? TMO : l;
    ebusy = (dd ? (dw ? 1 : leff) : 0) + (di ? leff : 0);
    if (l == 0 && (di || (dd && !dw))) exp_err = 1;
    last = (eic > edc ? eic : edc) + 3;
    gi = -1; gd = -1; ni = 0; nd = 0; nb = 0; nst = 0; gid = 0; gdd = 0;
    lat = l;
    @(posedge clk); #1;
    i_req = di; i_addr = ia; d_req = dd; d_wr = dw; d_addr = da; d_wdata = wd;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      if (i_stall !== (i_req && c != eic)) nst++;
      if (d_stall !== (d_req && c != edc)) nst++;
      if (mem_enable) nb++;
      if (i_ack) begin ni++; if (gi < 0) begin gi = c; gid = i_rdata; end i_req = 0; end
      if (d_ack) begin nd++; if (gd < 0) begin gd = c; gdd = d_rdata; end d_req = 0; end
      // Inputs only need to be stable until the grant edge.
      if (c == 1) begin
        if (dd) begin d_addr = 16'($urandom); d_wdata = 16'($urandom); end
        else i_addr = 16'($urandom);
      end
    end
    i_req = 0; d_req = 0;
    chk({nm, " i_cyc"}, gi, eic);
    chk({nm, " d_cyc"}, gd, edc);
    chk({nm, " acks"}, ni * 2 + nd, int'(di) * 2 + int'(dd));
    if (di) chk({nm, " i_rdata"}, int'(gid), int'(eid));
    if (dd) chk({nm, " d_rdata"}, int'(gdd), int'(edd));
    chk({nm, " busy"}, nb, ebusy);
    chk({nm, " stall"}, nst, 0);
    chk({nm, " err"}, int'(err), int'(exp_err));
    if (dd && dw) ref_mem[da] = wd;
    if (di) last_i = eid;
  endtask

  typedef struct {
    bit di, dd, dw;
    logic [15:0] ia, da, wd;
    int l, eic, edc;
    logic [15:0] eid, edd;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int gi, ni;
    for (int a = 0; a < 65536; a++) begin
      memarr[a] = 16'(a) ^ 16'h5A5A;
      ref_mem[a] = 16'(a) ^ 16'h5A5A;
    end
    memarr[16'h0010] = 16'hA5A5; ref_mem[16'h0010] = 16'hA5A5;
    memarr[16'h0200] = 16'hBEEF; ref_mem[16'h0200] = 16'hBEEF;

    tbl[0] = '{1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 3, 4, -1, 16'hA5A5, 16'h0000};
    tbl[1] = '{1, 1, 0, 16'h0010, 16'h0200, 16'h0000, 2, 6,  3, 16'hA5A5, 16'hBEEF};
    tbl[2] = '{0, 1, 1, 16'h0000, 16'h0300, 16'h1234, 2, -1, 2, 16'h0000, 16'h0000};
    tbl[3] = '{0, 1, 0, 16'h0000, 16'h0300, 16'h0000, 1, -1, 2, 16'h0000, 16'h1234};
    tbl[4] = '{1, 1, 1, 16'h0010, 16'h0010, 16'h5555, 1, 4,  2, 16'h5555, 16'h0000};
    tbl[5] = '{1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 4, 5, -1, 16'h5555, 16'h0000};

    repeat (3) @(posedge clk);
    #1;
    chk("rst acks", {i_ack, d_ack, mem_enable, mem_wr, err}, 0);
    chk("rst data", int'(mem_addr | mem_wdata | i_rdata | d_rdata), 0);
    rst = 0;

    for (int k = 0; k < 6; k++)
      xact(tbl[k].di, tbl[k].dd, tbl[k].dw, tbl[k].ia, tbl[k].da, tbl[k].wd,
           tbl[k].l, tbl[k].eic, tbl[k].edc, tbl[k].eid, tbl[k].edd, $sformatf("vec%0d", k));

    // Timeout on a data read: 15 BUSY cycles, zero data, sticky err.
    xact(0, 1, 0, 16'h0, 16'h0020, 16'h0, 0, -1, TMO + 1, 16'h0, 16'h0, "tmo");

    // Flush in BUSY cycle 2; the redirected fetch is then served from IDLE.
    lat = 3;
    @(posedge clk); #1;
    i_req = 1; i_addr = 16'h0020;
    gi = -1; ni = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin i_cancel = 1; i_addr = 16'h0040; end
      if (c == 3) i_cancel = 0;
      if (c == 4) begin
        chk("cancel idle", int'(mem_enable), 0);
        chk("cancel rdata", int'(i_rdata), int'(last_i));
      end
      if (i_ack) begin
        ni++;
        if (gi < 0) begin gi = c; chk("cancel new data", int'(i_rdata), int'(ref_mem[16'h0040])); end
        i_req = 0;
      end
    end
    chk("cancel ack cyc", gi, 8);
    chk("cancel ack cnt", ni, 1);
    last_i = ref_mem[16'h0040];

    xact(1, 0, 0, 16'h0011, 16'h0, 16'h0, 2, 3, -1, ref_mem[16'h0011], 16'h0, "err sticky");

    // Reset during the write cycle aborts it with no ack and no memory update.
    lat = 1;
    @(posedge clk); #1;
    d_req = 1; d_wr = 1; d_addr = 16'h0400; d_wdata = 16'h7777;
    @(posedge clk); #1;
    chk("wr strobe", int'(mem_wr), 1);
    rst = 1; #1;
    chk("async rst ctl", {d_ack, i_ack, mem_enable, mem_wr, err}, 0);
    chk("async rst data", int'(mem_addr | mem_wdata | i_rdata | d_rdata), 0);
    d_req = 0; d_wr = 0;
    @(posedge clk); #1;
    rst = 0; exp_err = 0; last_i = 0;
    ni = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (d_ack || i_ack) ni++;
    end
    chk("rst no ack", ni, 0);
    xact(0, 1, 0, 16'h0, 16'h0400, 16'h0, 1, -1, 2, 16'h0, ref_mem[16'h0400], "rst rd");
    xact(0, 1, 1, 16'h0, 16'h0400, 16'h7777, 1, -1, 2, 16'h0, 16'h0, "rst wr");
    xact(0, 1, 0, 16'h0, 16'h0400, 16'h0, 2, -1, 3, 16'h0, 16'h7777, "rst rb");

    for (int r = 0; r < 40; r++) begin
      bit di, dd, dw;
      int l, leff, edc, eic;
      logic [15:0] ia, da, wd, eid, edd;
      int kind;
      kind = $urandom_range(0, 3);
      di = (kind != 1); dd = (kind != 0);
      if (!di && !dd) di = 1;
      dw = dd && ($urandom_range(0, 1) == 1);
      l = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      leff = (l == 0) ? TMO : l;
      ia = 16'($urandom_range(0, 7)); da = 16'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) ia = 16'($urandom);
      wd = 16'($urandom);
      edc = -1; eic = -1; edd = 0; eid = 0;
      if (dd) begin
        edc = dw ? 2 : leff + 1;
        edd = (dw || l == 0) ? 16'h0 : ref_mem[da];
      end
      if (di) begin
        eic = (dd ? edc : 0) + leff + 1;
        eid = (l == 0) ? 16'h0 : ((dd && dw && da == ia) ? wd : ref_mem[ia]);
      end
      xact(di, dd, dw, ia, da, wd, l, eic, edc, eid, edd, $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
